axi4_lite_slave_ctrl: RTL
=========================

// Module: axi4_lite_slave_ctrl
// PURPOSE
//   Parametrised AXI4-Lite slave front end for the filter's register banks.
//   Converts AXI4-Lite transactions into simple register-port strobes (wr_en/rd_en).
//   Generalises the single-width, fixed-order slave:
//   - configurable data width
//   - AW and W channels accepted in any order
//   - configurable register-read latency
//   - SLVERR response for out-of-range addresses
// PARAMETERS
//   ADDR_BITS   8    byte-address width
//   DATA_BITS   32   data width; legal values are 32 or 64. STRB_BITS = DATA_BITS/8.
//   ADDR_LIMIT  64   first illegal byte address; addresses >= ADDR_LIMIT get SLVERR
//   RD_LATENCY  1    cycles from rd_en to valid rd_data, 0..7 (0 = combinational)
// PORTS
//   clk            in   1          clock, rising edge
//   rst            in   1          synchronous active-high reset
//   s_axi_awaddr   in   ADDR_BITS  write address
//   s_axi_awvalid  in   1 / s_axi_awready out 1    write address handshake
//   s_axi_wdata    in   DATA_BITS  write data
//   s_axi_wstrb    in   STRB_BITS  byte strobes
//   s_axi_wvalid   in   1 / s_axi_wready  out 1    write data handshake
//   s_axi_bresp    out  2          00 OKAY, 10 SLVERR
//   s_axi_bvalid   out  1 / s_axi_bready  in  1    write response handshake
//   s_axi_araddr   in   ADDR_BITS  read address
//   s_axi_arvalid  in   1 / s_axi_arready out 1    read address handshake
//   s_axi_rdata    out  DATA_BITS  read data
//   s_axi_rresp    out  2          00 OKAY, 10 SLVERR
//   s_axi_rvalid   out  1 / s_axi_rready  in  1    read data handshake
//   wr_addr        out  ADDR_BITS  aligned write address (low log2(STRB_BITS) bits = 0)
//   wr_en          out  1          one-cycle write strobe
//   wr_data        out  DATA_BITS  write data
//   wr_strb        out  STRB_BITS  byte enables
//   rd_addr        out  ADDR_BITS  aligned read address
//   rd_en          out  1          one-cycle read strobe
//   rd_data        in   DATA_BITS  register read data
// BEHAVIOUR
//   Reset values:
//   - bvalid=rvalid=wr_en=rd_en=0; bresp=rresp=0; rdata=0.
//   - wr_addr/wr_data/wr_strb/rd_addr=0; both FSMs IDLE, so awready=wready=arready=1.
//   Write FSM W_IDLE -> W_EXEC -> W_RESP:
//   - In W_IDLE: awready = !aw_got, wready = !w_got.
//   - Each handshake latches its own fields and sets its got flag.
//   - AW and W may arrive in either order or in the same cycle.
//   - When both flags are set (including in the same cycle), go to W_EXEC.
//   - W_EXEC, one cycle: wr_en=1 only if wr_addr < ADDR_LIMIT; flags clear; go to W_RESP.
//   - W_RESP: bvalid=1; bresp=10 if out of range, else 00; return to W_IDLE on bready.
//   - Best case: AW+W handshake at cycle 0, wr_en at cycle 1, bvalid from cycle 2.
//   Read FSM R_IDLE -> R_WAIT -> R_RESP:
//   - In R_IDLE: arready=1; a handshake latches rd_addr and goes to R_WAIT.
//   - R_WAIT: rd_en=1 on its first cycle, only if in range.
//   - A counter waits RD_LATENCY cycles, then rd_data is captured into rdata.
//   - Out of range: no rd_en; rdata=0, rresp=10; go straight to R_RESP after 1 cycle.
//   - R_RESP: rvalid=1; rdata/rresp stay stable until rready, then rdata clears to 0
//     and the FSM returns to R_IDLE.
//   - Latency: AR handshake at cycle 0, rd_en at cycle 1, rvalid from cycle 2+RD_LATENCY.
//   Write and read FSMs are independent; wr_en and rd_en may assert in the same cycle.
//   Only one outstanding transaction per direction; no new AW/W/AR is accepted
//   until the response handshake completes.
//   rst asserted mid-transaction: everything returns to reset values next cycle;
//   the pending response is dropped.
// TESTING
//   1. AW and W in the same cycle, addr 0x04, data 0xA5A5_0001, strb F
//      -> wr_en at +1 with the same values, bvalid at +2, bresp 00.
//   2. W two cycles before AW (addr 0x08)
//      -> wready low after W accepted; wr_en once, at AW+1; single bvalid.
//   3. Write to 0x40 with ADDR_LIMIT=64
//      -> no wr_en pulse; bresp=10.
//   4. Read 0x0C, RD_LATENCY=3, rd_data=0x1234_5678
//      -> rd_en at +1, rvalid at +5; rdata holds through 4 cycles of rready=0.
//   5. Simultaneous write to 0x10 and read from 0x14
//      -> both strobes fire in the same cycle; both responses are correct and independent.
//   6. rst pulsed while bvalid=1 and rvalid=1
//      -> next cycle bvalid=rvalid=0 and awready=arready=1.

Source files
------------

// File: rtl/axi4_lite_slave_ctrl.sv
// rtl/axi4_lite_slave_ctrl.sv - AXI4-Lite slave front end producing register-port strobes
// Independent write and read FSMs, one outstanding transaction per direction.
module axi4_lite_slave_ctrl #(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 32,
  parameter int ADDR_LIMIT = 64,
  parameter int RD_LATENCY = 1,
  parameter int STRB_BITS  = DATA_BITS / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [DATA_BITS-1:0] s_axi_wdata,
  input  logic [STRB_BITS-1:0] s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [ADDR_BITS-1:0] s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [DATA_BITS-1:0] s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic                 wr_en,
  output logic [DATA_BITS-1:0] wr_data,
  output logic [STRB_BITS-1:0] wr_strb,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_en,
  input  logic [DATA_BITS-1:0] rd_data
);

  localparam int                 LSB_BITS   = $clog2(STRB_BITS);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ~ADDR_BITS'((1 << LSB_BITS) - 1);
  localparam logic [ADDR_BITS:0]   LIMIT      = (ADDR_BITS + 1)'(ADDR_LIMIT);
  localparam logic [2:0]           LAT        = 3'(RD_LATENCY);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  w_state_t               w_state_q;
  r_state_t               r_state_q;
  logic                   aw_got_q, w_got_q, w_err_q, r_err_q;
  logic [ADDR_BITS-1:0]   wr_addr_q, rd_addr_q;
  logic [DATA_BITS-1:0]   wr_data_q, rdata_q;
  logic [STRB_BITS-1:0]   wr_strb_q;
  logic                   wr_en_q, rd_en_q, bvalid_q, rvalid_q;
  logic [1:0]             bresp_q, rresp_q;
  logic [2:0]             cnt_q;

  logic                   aw_hs, w_hs, ar_hs, wr_ok_d, rd_ok_d;
  logic [ADDR_BITS-1:0]   wr_addr_d, rd_addr_d;

  assign s_axi_awready = (w_state_q == W_IDLE) && !aw_got_q;
  assign s_axi_wready  = (w_state_q == W_IDLE) && !w_got_q;
  assign s_axi_arready = (r_state_q == R_IDLE);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Range check uses the address that will be in wr_addr_q once this cycle's AW lands.
  assign wr_addr_d = aw_hs ? (s_axi_awaddr & ALIGN_MASK) : wr_addr_q;
  assign wr_ok_d   = {1'b0, wr_addr_d} < LIMIT;
  assign rd_addr_d = s_axi_araddr & ALIGN_MASK;
  assign rd_ok_d   = {1'b0, rd_addr_d} < LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      w_err_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      wr_en_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            wr_addr_q <= wr_addr_d;
            aw_got_q  <= 1'b1;
          end
          if (w_hs) begin
            wr_data_q <= s_axi_wdata;
            wr_strb_q <= s_axi_wstrb;
            w_got_q   <= 1'b1;
          end
          if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
            wr_en_q   <= wr_ok_d;
            w_err_q   <= !wr_ok_d;
            w_state_q <= W_EXEC;
          end
        end
        W_EXEC: begin
          wr_en_q   <= 1'b0;
          aw_got_q  <= 1'b0;
          w_got_q   <= 1'b0;
          bvalid_q  <= 1'b1;
          bresp_q   <= w_err_q ? 2'b10 : 2'b00;
          w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_err_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      cnt_q     <= 3'd0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_ok_d;
            r_err_q   <= !rd_ok_d;
            cnt_q     <= 3'd0;
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          rd_en_q <= 1'b0;
          if (r_err_q) begin
            rdata_q   <= '0;
            rresp_q   <= 2'b10;
            rvalid_q  <= 1'b1;
            r_state_q <= R_RESP;
          end else if (cnt_q == LAT) begin
            // cnt_q == 0 is the rd_en cycle, so capture lands RD_LATENCY cycles after it.
            rdata_q   <= rd_data;
            rresp_q   <= 2'b00;
            rvalid_q  <= 1'b1;
            r_state_q <= R_RESP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_strb      = wr_strb_q;
  assign wr_en        = wr_en_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign rd_addr      = rd_addr_q;
  assign rd_en        = rd_en_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rvalid = rvalid_q;

endmodule
